// File: rtl/pacman_pkg.sv
// Shared constants for the Pacman video pipeline: sprite ROM indices, screen
// geometry and the sprite line renderer's state encoding.
package pacman_pkg;

   localparam logic [2:0] SPR_PAC_RIGHT = 3'd0;
   localparam logic [2:0] SPR_PAC_LEFT  = 3'd1;
   localparam logic [2:0] SPR_PAC_DOWN  = 3'd2;
   localparam logic [2:0] SPR_PAC_UP    = 3'd3;
   localparam logic [2:0] SPR_GHOST     = 3'd4;

   localparam int SPRITE_SIZE = 32;
   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 480;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_SWAP  = 2'd2
   } render_state_e;

endpackage

// File: rtl/sprite_row_slot.sv
// One actor's double-buffered sprite row: the back half is filled during the
// fetch, the front half drives the per-pixel coverage test.
module sprite_row_slot #(
   parameter int SPRITE_SIZE = 32
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        load_i,
   input  logic [31:0] row_i,
   input  logic [9:0]  x_i,
   input  logic        valid_i,
   input  logic        swap_i,
   input  logic [9:0]  draw_x_i,
   output logic        lit_o
);

   localparam logic [10:0] SIZE11 = 11'(SPRITE_SIZE);

   logic [31:0] back_row_q, front_row_q;
   logic [9:0]  back_x_q, front_x_q;
   logic        back_valid_q, front_valid_q;
   logic [10:0] dx;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         back_row_q    <= '0;
         back_x_q      <= '0;
         back_valid_q  <= 1'b0;
         front_row_q   <= '0;
         front_x_q     <= '0;
         front_valid_q <= 1'b0;
      end else begin
         if (load_i) begin
            back_row_q   <= row_i;
            back_x_q     <= x_i;
            back_valid_q <= valid_i;
         end
         if (swap_i) begin
            front_row_q   <= back_row_q;
            front_x_q     <= back_x_q;
            front_valid_q <= back_valid_q;
         end
      end
   end

   // dx[10] set means draw_x is left of the sprite.
   always_comb begin
      dx    = {1'b0, draw_x_i} - {1'b0, front_x_q};
      lit_o = front_valid_q && !dx[10] && (dx < SIZE11) &&
              front_row_q[5'd31 - dx[4:0]];
   end

endmodule

// File: rtl/sprite_line_renderer.sv
// Fetches one sprite row per actor into the slots during blanking and
// priority-encodes their per-pixel coverage during the visible line.
module sprite_line_renderer #(
   parameter int NUM_ACTORS  = 5,
   parameter int SPRITE_SIZE = 32
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic                      line_start,
   input  logic [9:0]                next_line_y,
   input  logic [NUM_ACTORS*10-1:0]  actor_x,
   input  logic [NUM_ACTORS*10-1:0]  actor_y,
   input  logic [NUM_ACTORS*3-1:0]   actor_sprite,
   output logic [7:0]                rom_addr,
   input  logic [31:0]               rom_data,
   input  logic [9:0]                draw_x,
   output logic                      pixel_on,
   output logic [2:0]                pixel_actor,
   output logic                      busy,
   output logic                      fetch_done,
   output logic                      overrun,
   output pacman_pkg::render_state_e dbg_state
);
   import pacman_pkg::*;

   localparam int KW = (NUM_ACTORS > 1) ? $clog2(NUM_ACTORS) : 1;
   localparam logic [KW-1:0]  K_LAST = KW'(NUM_ACTORS - 1);
   localparam logic [10:0]    SIZE11 = 11'(SPRITE_SIZE);

   render_state_e   state_q, state_d;
   logic [KW-1:0]   k_q, k_d;
   logic [9:0]      line_y_q;
   logic [9:0]      sh_x_q   [NUM_ACTORS];
   logic [9:0]      sh_y_q   [NUM_ACTORS];
   logic [2:0]      sh_spr_q [NUM_ACTORS];
   logic [7:0]      rom_addr_q, fetch_addr;
   logic            overrun_q, pixel_on_q;
   logic [2:0]      pixel_actor_q, winner;
   logic [10:0]     dy;
   logic            hit, load_en, swap_en;
   logic [31:0]     row_in;
   logic [9:0]      x_in;
   logic [NUM_ACTORS-1:0] lit;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         ST_IDLE: begin
            if (line_start) begin
               state_d = ST_FETCH;
               k_d     = '0;
            end
         end
         ST_FETCH: begin
            if (k_q == K_LAST) state_d = ST_SWAP;
            else               k_d     = k_q + 1'b1;
         end
         ST_SWAP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // The shadow copy isolates the fetch from game-state updates mid-line.
   always_comb begin
      dy         = {1'b0, line_y_q} - {1'b0, sh_y_q[k_q]};
      hit        = !dy[10] && (dy < SIZE11);
      fetch_addr = {sh_spr_q[k_q], dy[4:0]};
      row_in     = hit ? rom_data : '0;
      x_in       = sh_x_q[k_q];
      load_en    = (state_q == ST_FETCH);
      swap_en    = (state_q == ST_SWAP);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q       <= ST_IDLE;
         k_q           <= '0;
         line_y_q      <= '0;
         rom_addr_q    <= '0;
         overrun_q     <= 1'b0;
         pixel_on_q    <= 1'b0;
         pixel_actor_q <= '0;
         for (int i = 0; i < NUM_ACTORS; i++) begin
            sh_x_q[i]   <= '0;
            sh_y_q[i]   <= '0;
            sh_spr_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         k_q           <= k_d;
         pixel_on_q    <= |lit;
         pixel_actor_q <= winner;
         if (state_q == ST_IDLE && line_start) begin
            line_y_q <= next_line_y;
            for (int i = 0; i < NUM_ACTORS; i++) begin
               sh_x_q[i]   <= actor_x[10*i +: 10];
               sh_y_q[i]   <= actor_y[10*i +: 10];
               sh_spr_q[i] <= actor_sprite[3*i +: 3];
            end
         end
         if (load_en) rom_addr_q <= fetch_addr;
         if (line_start && state_q != ST_IDLE) overrun_q <= 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_ACTORS; g++) begin : g_slot
      sprite_row_slot #(.SPRITE_SIZE(SPRITE_SIZE)) u_slot (
         .Clk      (Clk),
         .Reset    (Reset),
         .load_i   (load_en && (k_q == KW'(g))),
         .row_i    (row_in),
         .x_i      (x_in),
         .valid_i  (hit),
         .swap_i   (swap_en),
         .draw_x_i (draw_x),
         .lit_o    (lit[g])
      );
   end

   // Scan from the top down so the lowest lit index wins.
   always_comb begin
      winner = '0;
      for (int i = NUM_ACTORS - 1; i >= 0; i--) begin
         if (lit[i]) winner = 3'(i);
      end
   end

   // rom_addr follows the fetch combinationally and holds its last value in IDLE.
   assign rom_addr    = load_en ? fetch_addr : rom_addr_q;
   assign pixel_on    = pixel_on_q;
   assign pixel_actor = pixel_actor_q;
   assign busy        = (state_q != ST_IDLE);
   assign fetch_done  = swap_en;
   assign overrun     = overrun_q;
   assign dbg_state   = state_q;

endmodule
